// File: rtl/if_id_fifo_if.sv
// IF -> ID decoupling buffer bus: fetch side inputs, flush/stall controls and head-entry outputs.
interface if_id_fifo_if;
   logic        flush_i;
   logic [31:0] pc_i;
   logic        ce_i;
   logic [31:0] inst_i;
   logic        stall_i;
   logic        stall_req_o;
   logic        valid_o;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        excp_adel_o;

   modport master (
      output flush_i, pc_i, ce_i, inst_i, stall_i,
      input  stall_req_o, valid_o, pc_o, inst_o, excp_adel_o
   );

   modport slave (
      input  flush_i, pc_i, ce_i, inst_i, stall_i,
      output stall_req_o, valid_o, pc_o, inst_o, excp_adel_o
   );
endinterface

// File: rtl/if_id_fifo.sv
// In-order fetch buffer between IF and ID; pairs each accepted pc with the SRAM word returned a cycle later.
// Optional fetch address-error tagging is enabled by defining FETCH_ADEL_CHECK_EN.
module if_id_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input logic         clk_i,
   input logic         rst_i,
   if_id_fifo_if.slave bus
);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             req_pend;
   logic [31:0]      req_pc;

   logic [31:0]      mem_pc   [DEPTH];
   logic [31:0]      mem_inst [DEPTH];

   logic             accept;
   logic             wr_en;
   logic             pop;
   logic             valid;
   logic [PTR_W+1:0] occupancy;
   logic [31:0]      wr_inst;
   logic             head_adel;

   assign valid     = (count != '0);
   // In-flight request counts as occupied so its write can never land on a full buffer.
   assign occupancy = {1'b0, count} + {{(PTR_W+1){1'b0}}, req_pend};

   assign bus.stall_req_o = (occupancy >= (PTR_W+2)'(DEPTH - 1));
   assign accept = bus.ce_i & ~bus.stall_req_o & ~bus.flush_i;
   assign wr_en  = req_pend & ~bus.flush_i;
   assign pop    = valid & ~bus.stall_i & ~bus.flush_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         req_pend <= 1'b0;
         req_pc   <= '0;
      end else if (bus.flush_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         req_pend <= 1'b0;
      end else begin
         req_pend <= accept;
         if (accept) req_pc <= bus.pc_i;
         if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PTR_W+1)'(wr_en) - (PTR_W+1)'(pop);
      end
   end

`ifdef FETCH_ADEL_CHECK_EN
   logic req_adel;
   logic mem_adel [DEPTH];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)       req_adel <= 1'b0;
      else if (accept) req_adel <= (bus.pc_i[1:0] != 2'b00);
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_adel[wr_ptr] <= req_adel;
   end

   // Misaligned fetches carry a NOP so ID never decodes a bogus word.
   assign wr_inst   = req_adel ? '0 : bus.inst_i;
   assign head_adel = mem_adel[rd_ptr];
`else
   assign wr_inst   = bus.inst_i;
   assign head_adel = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_pc[wr_ptr]   <= req_pc;
         mem_inst[wr_ptr] <= wr_inst;
      end
   end

   always_comb begin
      bus.valid_o     = valid;
      bus.pc_o        = '0;
      bus.inst_o      = '0;
      bus.excp_adel_o = 1'b0;
      if (valid) begin
         bus.pc_o        = mem_pc[rd_ptr];
         bus.inst_o      = mem_inst[rd_ptr];
         bus.excp_adel_o = head_adel;
      end
   end

endmodule

// File: tb/tb_if_id_fifo.sv
// Randomized and directed bench for if_id_fifo against a queue-based reference model.
module tb_if_id_fifo;
   localparam int unsigned DEPTH = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   if_id_fifo_if bus ();

   if_id_fifo #(.DEPTH(DEPTH), .PTR_W(2)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   ent_t        q[$];
   bit          pend;
   logic [31:0] pend_pc;
   int          tests_run;
   int          tests_failed;
   logic [31:0] fetch_pc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_stall_req();
      return (q.size() + int'(pend)) >= int'(DEPTH - 1);
   endfunction

   task automatic check_outputs(input string tag);
      ent_t h;
      h = '0;
      if (q.size() != 0) h = q[0];
      check({tag, ".valid"},     64'(bus.valid_o),     64'(q.size() != 0));
      check({tag, ".stall_req"}, 64'(bus.stall_req_o), 64'(model_stall_req()));
      check({tag, ".pc"},        64'(bus.pc_o),        64'(h.pc));
      check({tag, ".inst"},      64'(bus.inst_o),      64'(h.inst));
      check({tag, ".adel"},      64'(bus.excp_adel_o), 64'(h.adel));
   endtask

   // Called at posedge+1; drives one cycle of inputs, advances the model over the edge, then checks.
   task automatic step(input string tag, input logic ce, input logic [31:0] pc,
                       input logic [31:0] inst, input logic stall, input logic flush,
                       output bit acc);
      ent_t e;
      bus.ce_i    = ce;
      bus.pc_i    = pc;
      bus.inst_i  = inst;
      bus.stall_i = stall;
      bus.flush_i = flush;
      acc = ce && !model_stall_req() && !flush;
      @(posedge clk);
      if (flush) begin
         q.delete();
         pend = 0;
      end else begin
         if (q.size() != 0 && !stall) void'(q.pop_front());
         if (pend) begin
            e.pc = pend_pc;
`ifdef FETCH_ADEL_CHECK_EN
            e.adel = (pend_pc[1:0] != 2'b00);
            e.inst = e.adel ? 32'h0 : inst;
`else
            e.adel = 1'b0;
            e.inst = inst;
`endif
            q.push_back(e);
         end
         pend    = acc;
         pend_pc = pc;
      end
      #1;
      if (q.size() > DEPTH) begin
         tests_failed++;
         $display("FAIL %s.overflow: model holds %0d entries, limit %0d", tag, q.size(), DEPTH);
      end
      check_outputs(tag);
   endtask

   task automatic idle(input string tag, input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(tag, 1'b0, 32'h0, $urandom, 1'b0, 1'b0, acc);
   endtask

   task automatic scenario1(input string tag);
      bit acc;
      step(tag, 1'b1, 32'hBFC0_0000, $urandom,    1'b0, 1'b0, acc);
      check({tag, ".acc0"}, 64'(acc), 64'd1);
      check({tag, ".lat1"}, 64'(bus.valid_o), 64'd0);
      step(tag, 1'b1, 32'hBFC0_0004, 32'h2401_0001, 1'b0, 1'b0, acc);
      check({tag, ".lat2"}, 64'(bus.valid_o), 64'd1);
      check({tag, ".first_pc"}, 64'(bus.pc_o), 64'hBFC0_0000);
      step(tag, 1'b0, 32'h0,         32'h2402_0002, 1'b0, 1'b0, acc);
      check({tag, ".second_inst"}, 64'(bus.inst_o), 64'h2402_0002);
      idle(tag, 2);
   endtask

   initial begin
      bit acc;
      tests_run = 0;
      tests_failed = 0;
      pend = 0;
      pend_pc = '0;
      bus.ce_i = 0; bus.pc_i = '0; bus.inst_i = '0; bus.stall_i = 0; bus.flush_i = 0;

      #12;
      check_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_outputs("post_reset");

      scenario1("s1");

      // Stalled ID: IF keeps fetching until back-pressured, then everything drains in order.
      fetch_pc = 32'hBFC0_0100;
      for (int i = 0; i < 8; i++) begin
         step("s2_stall", 1'b1, fetch_pc, $urandom, 1'b1, 1'b0, acc);
         if (acc) fetch_pc += 4;
      end
      check("s2.backpressure", 64'(bus.stall_req_o), 64'd1);
      for (int i = 0; i < 10; i++) begin
         step("s2_drain", 1'b1, fetch_pc, $urandom, 1'b0, 1'b0, acc);
         if (acc) fetch_pc += 4;
      end
      idle("s2_idle", 4);

      // Full-rate streaming across pointer wrap.
      fetch_pc = 32'hBFC0_0200;
      for (int i = 0; i < 10; i++) begin
         step("s3", 1'b1, fetch_pc, $urandom, 1'b0, 1'b0, acc);
         check("s3.accept", 64'(acc), 64'd1);
         fetch_pc += 4;
      end
      idle("s3_idle", 3);

      // Flush with two entries buffered and one request in flight.
      fetch_pc = 32'hBFC0_0300;
      for (int i = 0; i < 3; i++) begin
         step("s4_fill", 1'b1, fetch_pc, $urandom, 1'b1, 1'b0, acc);
         fetch_pc += 4;
      end
      check("s4.pre_valid", 64'(bus.valid_o), 64'd1);
      step("s4_flush", 1'b0, fetch_pc, $urandom, 1'b1, 1'b1, acc);
      check("s4.flush_valid", 64'(bus.valid_o), 64'd0);
      check("s4.flush_stall", 64'(bus.stall_req_o), 64'd0);
      step("s4_new", 1'b1, 32'hBFC0_0380, 32'hDEAD_BEEF, 1'b0, 1'b0, acc);
      step("s4_new", 1'b0, 32'h0, 32'h3C08_0001, 1'b0, 1'b0, acc);
      check("s4.first_pc", 64'(bus.pc_o), 64'hBFC0_0380);
      check("s4.first_inst", 64'(bus.inst_o), 64'h3C08_0001);
      idle("s4_idle", 2);

      // Asynchronous reset between edges with traffic in flight.
      fetch_pc = 32'hBFC0_0400;
      for (int i = 0; i < 3; i++) begin
         step("s5_pre", 1'b1, fetch_pc, $urandom, 1'b1, 1'b0, acc);
         fetch_pc += 4;
      end
      #2;
      rst = 1'b1;
      #1;
      q.delete();
      pend = 0;
      check_outputs("s5_async");
      bus.ce_i = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_outputs("s5_release");
      scenario1("s5_refetch");

      // Misaligned fetch address.
      step("s6", 1'b1, 32'hBFC0_0002, $urandom, 1'b0, 1'b0, acc);
      step("s6", 1'b0, 32'h0, 32'h1234_5678, 1'b0, 1'b0, acc);
`ifdef FETCH_ADEL_CHECK_EN
      check("s6.adel", 64'(bus.excp_adel_o), 64'd1);
      check("s6.nop", 64'(bus.inst_o), 64'd0);
`else
      check("s6.adel", 64'(bus.excp_adel_o), 64'd0);
      check("s6.inst", 64'(bus.inst_o), 64'h1234_5678);
`endif
      idle("s6_idle", 2);

      // Random traffic.
      fetch_pc = 32'hBFC0_1000;
      for (int i = 0; i < 400; i++) begin
         logic [31:0] pc;
         pc = fetch_pc;
         if ($urandom_range(9) == 0) pc[1:0] = 2'($urandom);
         step("rand", ($urandom_range(9) < 8), pc, $urandom,
              ($urandom_range(9) < 3), ($urandom_range(39) == 0), acc);
         if (acc) fetch_pc += 4;
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end
endmodule
